// File: rtl/sb_tx_pkg.sv
// Shared types and helpers for the sideband transmit scheduler.
// States: IDLE wait | PATTERN_GEN burst | ENCODE | DATA_FRAME | HEADER_FRAME | END_MESSAGE.
package sb_tx_pkg;

  localparam int SB_TX_MIN_GID_W = 1;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_PATTERN_GEN  = 3'd1,
    S_ENCODE       = 3'd2,
    S_DATA_FRAME   = 3'd3,
    S_HEADER_FRAME = 3'd4,
    S_END_MESSAGE  = 3'd5
  } e_sb_tx_state;

  function automatic int f_gid_w(input int n);
    return (n > 1) ? $clog2(n) : SB_TX_MIN_GID_W;
  endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after the pointer.
module sb_rr_arbiter
  import sb_tx_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int GID_W  = f_gid_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [GID_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [GID_W-1:0]  o_gnt_id,
  output logic              o_any
);

  int                w_idx;
  logic [NUM_CH-1:0] w_oh;

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    o_any    = 1'b0;
    w_idx    = 0;
    w_oh     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_CH;
      w_oh  = NUM_CH'(1) << w_idx;
      if (!o_any && (|(i_req & w_oh))) begin
        o_any    = 1'b1;
        o_gnt    = w_oh;
        o_gnt_id = GID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: pattern-first, then round-robin message sequencing.
// Optional watchdog on encode/frame waits enabled by defining SB_TX_TIMEOUT_EN.
module sb_tx_scheduler
  import sb_tx_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int PATTERN_ITER = 4,
  parameter int TIMEOUT_CYC  = 256,
  localparam int GID_W       = f_gid_w(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pattern_req,
  input  logic              i_pattern_beat_done,
  input  logic [NUM_CH-1:0] i_msg_valid,
  input  logic [NUM_CH-1:0] i_msg_has_data,
  input  logic              i_enc_done,
  input  logic              i_frame_done,
  output logic [NUM_CH-1:0] o_msg_ready,
  output logic [GID_W-1:0]  o_grant_id,
  output logic              o_pattern_enable,
  output logic              o_header_encoder_enable,
  output logic              o_data_encoder_enable,
  output logic              o_data_frame_enable,
  output logic              o_header_frame_enable,
  output logic              o_pattern_done,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam int BEAT_W = $clog2(PATTERN_ITER + 1);

  if (NUM_CH < 1 || PATTERN_ITER < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("sb_tx_scheduler: NUM_CH, PATTERN_ITER and TIMEOUT_CYC must be >= 1");
  end

  e_sb_tx_state      r_state, w_state_nxt;
  logic [GID_W-1:0]  r_grant, r_ptr, w_arb_id, w_grant_inc;
  logic [NUM_CH-1:0] w_arb_gnt, w_ready_nxt;
  logic              w_arb_any, w_arb_has_data, r_has_data;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              w_beat_last, w_wd_expire, w_latch, w_ptr_adv;
  logic              w_hdr_enc_nxt, w_data_enc_nxt, w_data_frm_nxt, w_hdr_frm_nxt;
  logic              w_pat_done_nxt, w_timeout_nxt;
  logic              r_timeout;

  sb_rr_arbiter #(.NUM_CH(NUM_CH), .GID_W(GID_W)) u_arb (
    .i_req    (i_msg_valid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_arb_gnt),
    .o_gnt_id (w_arb_id),
    .o_any    (w_arb_any)
  );

  assign w_arb_has_data = |(i_msg_has_data & w_arb_gnt);
  assign w_beat_last    = i_pattern_beat_done && (r_beat_cnt == BEAT_W'(PATTERN_ITER - 1));
  assign w_grant_inc    = (r_grant == GID_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
  assign o_busy         = (r_state != S_IDLE);

`ifdef SB_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wait_st;

  assign w_wait_st   = (r_state == S_ENCODE) || (r_state == S_DATA_FRAME) ||
                       (r_state == S_HEADER_FRAME);
  assign w_wd_expire = w_wait_st && (r_wd_cnt == '0);
  assign o_timeout   = r_timeout;

  // Down-counter reloaded on every state change so each wait gets its own budget.
  always_ff @(posedge i_clk) begin
    if (i_rst)                        r_wd_cnt <= '0;
    else if (w_state_nxt != r_state)  r_wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
    else if (w_wait_st && r_wd_cnt != '0) r_wd_cnt <= r_wd_cnt - 1'b1;
  end
`else
  assign w_wd_expire = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_ready_nxt    = '0;
    w_hdr_enc_nxt  = 1'b0;
    w_data_enc_nxt = 1'b0;
    w_data_frm_nxt = 1'b0;
    w_hdr_frm_nxt  = 1'b0;
    w_pat_done_nxt = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_latch        = 1'b0;
    w_ptr_adv      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_pattern_req) begin
          w_state_nxt = S_PATTERN_GEN;
        end else if (w_arb_any) begin
          w_state_nxt    = S_ENCODE;
          w_ready_nxt    = w_arb_gnt;
          w_hdr_enc_nxt  = 1'b1;
          w_data_enc_nxt = w_arb_has_data;
          w_latch        = 1'b1;
        end
      end
      S_PATTERN_GEN: begin
        if (w_beat_last) begin
          w_state_nxt    = S_IDLE;
          w_pat_done_nxt = 1'b1;
        end
      end
      S_ENCODE: begin
        if (i_enc_done) begin
          w_state_nxt    = r_has_data ? S_DATA_FRAME : S_HEADER_FRAME;
          w_data_frm_nxt = r_has_data;
          w_hdr_frm_nxt  = !r_has_data;
        end else if (w_wd_expire) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
          w_ptr_adv     = 1'b1;
        end
      end
      S_DATA_FRAME: begin
        if (i_frame_done) begin
          w_state_nxt   = S_HEADER_FRAME;
          w_hdr_frm_nxt = 1'b1;
        end else if (w_wd_expire) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
          w_ptr_adv     = 1'b1;
        end
      end
      S_HEADER_FRAME: begin
        if (i_frame_done) begin
          w_state_nxt = S_END_MESSAGE;
        end else if (w_wd_expire) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
          w_ptr_adv     = 1'b1;
        end
      end
      S_END_MESSAGE: begin
        w_state_nxt = S_IDLE;
        w_ptr_adv   = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state                 <= S_IDLE;
      r_grant                 <= '0;
      r_ptr                   <= '0;
      r_has_data              <= 1'b0;
      r_beat_cnt              <= '0;
      r_timeout               <= 1'b0;
      o_msg_ready             <= '0;
      o_pattern_enable        <= 1'b0;
      o_header_encoder_enable <= 1'b0;
      o_data_encoder_enable   <= 1'b0;
      o_data_frame_enable     <= 1'b0;
      o_header_frame_enable   <= 1'b0;
      o_pattern_done          <= 1'b0;
    end else begin
      r_state                 <= w_state_nxt;
      r_timeout               <= w_timeout_nxt;
      o_msg_ready             <= w_ready_nxt;
      o_pattern_enable        <= (w_state_nxt == S_PATTERN_GEN);
      o_header_encoder_enable <= w_hdr_enc_nxt;
      o_data_encoder_enable   <= w_data_enc_nxt;
      o_data_frame_enable     <= w_data_frm_nxt;
      o_header_frame_enable   <= w_hdr_frm_nxt;
      o_pattern_done          <= w_pat_done_nxt;
      if (w_latch) begin
        r_grant    <= w_arb_id;
        r_has_data <= w_arb_has_data;
      end
      if (w_ptr_adv) r_ptr <= w_grant_inc;
      if (r_state == S_PATTERN_GEN && i_pattern_beat_done)
        r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + 1'b1;
    end
  end

  assign o_grant_id = r_grant;

endmodule
